// File: rtl/cache_refill.sv
// Line-refill engine: fetches one cache line over an AXI4 INCR read burst, writes every
// 64-bit beat into the selected way's data banks, then writes the tag and reports done/err.
module cache_refill #(
   parameter int DW    = 1024,
   parameter int BK    = 4,
   parameter int CB    = 1,
   parameter int CL    = 256,
   parameter int TAG_W = 32
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_addr,
   input  logic [CB-1:0]    req_way,
   output logic             done,
   output logic             err,
   output logic [31:0]      M_AXI_ARADDR,
   output logic [7:0]       M_AXI_ARLEN,
   output logic [2:0]       M_AXI_ARSIZE,
   output logic [1:0]       M_AXI_ARBURST,
   output logic             M_AXI_ARVALID,
   input  logic             M_AXI_ARREADY,
   input  logic [63:0]      M_AXI_RDATA,
   input  logic [1:0]       M_AXI_RRESP,
   input  logic             M_AXI_RLAST,
   input  logic             M_AXI_RVALID,
   output logic             M_AXI_RREADY,
   output logic [31:0]      cache_addr,
   output logic [CB-1:0]    cache_en_w,
   output logic [7:0]       cache_info_wstrb,
   output logic [63:0]      cache_info_w,
   output logic [31:0]      tag_addr,
   output logic [CB-1:0]    tag_en_w,
   output logic [TAG_W-1:0] tag_info_w
);

   localparam int LINE_BYTES = DW * BK / 8;
   localparam int BEATS      = DW * BK / 64;
   localparam int ADDR_LSB   = $clog2(LINE_BYTES);
   localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
   localparam logic [7:0]       AR_LEN   = 8'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_RD   = 3'd2,
      S_TAG  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t             r_state;
   logic               r_req_ready;
   logic [31:0]        r_base;
   logic [CB-1:0]      r_way;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err_sticky;
   logic               r_done;
   logic               r_err;
   logic [31:0]        r_araddr;
   logic [7:0]         r_arlen;
   logic [2:0]         r_arsize;
   logic [1:0]         r_arburst;
   logic               r_arvalid;
   logic               r_rready;
   logic [31:0]        r_cache_addr;
   logic [CB-1:0]      r_cache_en;
   logic [7:0]         r_wstrb;
   logic [63:0]        r_cache_data;
   logic [31:0]        r_tag_addr;
   logic [CB-1:0]      r_tag_en;
   logic [TAG_W-1:0]   r_tag_info;

   logic [31:0]        w_req_base;
   logic [31:0]        w_beat_addr;
   logic               w_beat;
   logic               w_last_cnt;
   logic               w_beat_err;
   logic               w_unused;

   assign w_req_base  = {req_addr[31:ADDR_LSB], {ADDR_LSB{1'b0}}};
   assign w_beat_addr = r_base + {{(32-CNT_W-3){1'b0}}, r_cnt, 3'b000};
   assign w_beat      = M_AXI_RVALID & r_rready;
   assign w_last_cnt  = (r_cnt == LAST_CNT);
   // RLAST must coincide exactly with the final counted beat; anything else is a framing error.
   assign w_beat_err  = (M_AXI_RRESP != 2'b00) | (M_AXI_RLAST != w_last_cnt);
   assign w_unused    = ^{req_addr[ADDR_LSB-1:0], (CL > 0)};

   // Refill FSM together with every registered output it drives.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_base       <= 32'd0;
         r_way        <= '0;
         r_cnt        <= '0;
         r_err_sticky <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_araddr     <= 32'd0;
         r_arlen      <= 8'd0;
         r_arsize     <= 3'd0;
         r_arburst    <= 2'd0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_cache_addr <= 32'd0;
         r_cache_en   <= '0;
         r_wstrb      <= 8'd0;
         r_cache_data <= 64'd0;
         r_tag_addr   <= 32'd0;
         r_tag_en     <= '0;
         r_tag_info   <= '0;
      end else begin
         r_cache_en <= '0;
         r_tag_en   <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_req_ready && req_valid) begin
                  r_req_ready <= 1'b0;
                  r_base      <= w_req_base;
                  r_way       <= req_way;
                  r_cnt       <= '0;
                  r_araddr    <= w_req_base;
                  r_arlen     <= AR_LEN;
                  r_arsize    <= 3'd3;
                  r_arburst   <= 2'b01;
                  r_arvalid   <= 1'b1;
                  r_state     <= S_AR;
               end else begin
                  r_req_ready <= 1'b1;
               end
            end
            S_AR: begin
               if (M_AXI_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= S_RD;
               end
            end
            S_RD: begin
               if (w_beat) begin
                  r_cache_en   <= r_way;
                  r_cache_addr <= w_beat_addr;
                  r_cache_data <= M_AXI_RDATA;
                  r_wstrb      <= 8'hFF;
                  if (w_beat_err) begin
                     r_err_sticky <= 1'b1;
                  end
                  if (w_last_cnt) begin
                     r_rready <= 1'b0;
                     r_state  <= S_TAG;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            S_TAG: begin
               // The last data write is on the outputs now, so the tag lands one cycle after it.
               r_tag_en   <= r_err_sticky ? '0 : r_way;
               r_tag_addr <= r_base;
               r_tag_info <= r_base[31 -: TAG_W];
               r_state    <= S_DONE;
            end
            S_DONE: begin
               r_done       <= 1'b1;
               r_err        <= r_err_sticky;
               r_err_sticky <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready        = r_req_ready;
   assign done             = r_done;
   assign err              = r_err;
   assign M_AXI_ARADDR     = r_araddr;
   assign M_AXI_ARLEN      = r_arlen;
   assign M_AXI_ARSIZE     = r_arsize;
   assign M_AXI_ARBURST    = r_arburst;
   assign M_AXI_ARVALID    = r_arvalid;
   assign M_AXI_RREADY     = r_rready;
   assign cache_addr       = r_cache_addr;
   assign cache_en_w       = r_cache_en;
   assign cache_info_wstrb = r_wstrb;
   assign cache_info_w     = r_cache_data;
   assign tag_addr         = r_tag_addr;
   assign tag_en_w         = r_tag_en;
   assign tag_info_w       = r_tag_info;

endmodule

// File: tb/tb_cache_refill.sv
// Bench for cache_refill: table of refill scenarios driven through an AXI slave model, with a
// scoreboard of expected cache writes plus a hand-written mid-refill reset sequence.
module tb_cache_refill;

   localparam int CB    = 1;
   localparam int TAG_W = 32;
   localparam int BEATS = 64;

   logic             CLK = 1'b0;
   logic             RSTn;
   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_addr;
   logic [CB-1:0]    req_way;
   logic             done;
   logic             err;
   logic [31:0]      M_AXI_ARADDR;
   logic [7:0]       M_AXI_ARLEN;
   logic [2:0]       M_AXI_ARSIZE;
   logic [1:0]       M_AXI_ARBURST;
   logic             M_AXI_ARVALID;
   logic             M_AXI_ARREADY;
   logic [63:0]      M_AXI_RDATA;
   logic [1:0]       M_AXI_RRESP;
   logic             M_AXI_RLAST;
   logic             M_AXI_RVALID;
   logic             M_AXI_RREADY;
   logic [31:0]      cache_addr;
   logic [CB-1:0]    cache_en_w;
   logic [7:0]       cache_info_wstrb;
   logic [63:0]      cache_info_w;
   logic [31:0]      tag_addr;
   logic [CB-1:0]    tag_en_w;
   logic [TAG_W-1:0] tag_info_w;

   cache_refill dut (
      .CLK(CLK), .RSTn(RSTn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_way(req_way),
      .done(done), .err(err),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
      .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
      .cache_addr(cache_addr), .cache_en_w(cache_en_w), .cache_info_wstrb(cache_info_wstrb),
      .cache_info_w(cache_info_w), .tag_addr(tag_addr), .tag_en_w(tag_en_w), .tag_info_w(tag_info_w)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0]   addr;
      logic [31:0]   base;
      logic [CB-1:0] way;
      int            ar_delay;
      int            gap;
      int            bad_beat;
      int            last_beat;
      logic [31:0]   dpat;
      logic          exp_err;
      int            exp_tags;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [63:0] d;
   } wr_t;

   vec_t          vecs[6];
   wr_t           exp_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_wr     = 0;
   int            n_tag    = 0;
   logic [31:0]   cur_base = 32'd0;
   logic [CB-1:0] cur_way  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every cache write must match the oldest accepted beat; tags only after all data.
   always @(negedge CLK) begin
      if (RSTn) begin
         if (cache_en_w != '0) begin
            n_wr++;
            check("write_has_beat", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               wr_t e;
               e = exp_q.pop_front();
               check("wr_addr", 64'(cache_addr), 64'(e.a));
               check("wr_data", cache_info_w, e.d);
               check("wr_way", 64'(cache_en_w), 64'(cur_way));
               check("wr_strb", 64'(cache_info_wstrb), 64'hFF);
            end
         end
         if (tag_en_w != '0) begin
            n_tag++;
            check("tag_way", 64'(tag_en_w), 64'(cur_way));
            check("tag_addr", 64'(tag_addr), 64'(cur_base));
            check("tag_info", 64'(tag_info_w), 64'(cur_base));
            check("tag_after_data", 64'(exp_q.size()), 64'd0);
         end
      end
   end

   task automatic check_idle_outs(input string name);
      logic any;
      any = M_AXI_ARVALID | M_AXI_RREADY | done | err | (|cache_en_w) | (|tag_en_w)
          | (|M_AXI_ARADDR) | (|M_AXI_ARLEN) | (|M_AXI_ARSIZE) | (|M_AXI_ARBURST)
          | (|cache_addr) | (|cache_info_w) | (|cache_info_wstrb) | (|tag_addr) | (|tag_info_w);
      check({name, "_ready"}, 64'(req_ready), 64'd1);
      check({name, "_outs_zero"}, 64'(any), 64'd0);
   endtask

   task automatic do_req(input vec_t v);
      int t = 0;
      while (!req_ready && t < 20) begin
         @(negedge CLK);
         t++;
      end
      check("req_ready_idle", 64'(req_ready), 64'd1);
      cur_base  = v.base;
      cur_way   = v.way;
      req_valid = 1'b1;
      req_addr  = v.addr;
      req_way   = v.way;
      @(posedge CLK);
      #1 req_valid = 1'b0;
      req_addr = 32'hDEAD_BEEF;
      @(negedge CLK);
      check("req_ready_busy", 64'(req_ready), 64'd0);
   endtask

   task automatic do_ar(input vec_t v);
      for (int i = 0; i < v.ar_delay; i++) begin
         check("arvalid_wait", 64'(M_AXI_ARVALID), 64'd1);
         check("araddr_wait", 64'(M_AXI_ARADDR), 64'(v.base));
         check("rready_before_ar", 64'(M_AXI_RREADY), 64'd0);
         @(negedge CLK);
      end
      check("arvalid", 64'(M_AXI_ARVALID), 64'd1);
      check("araddr", 64'(M_AXI_ARADDR), 64'(v.base));
      check("arlen", 64'(M_AXI_ARLEN), 64'd63);
      check("arsize", 64'(M_AXI_ARSIZE), 64'd3);
      check("arburst", 64'(M_AXI_ARBURST), 64'd1);
      check("rready_before_ar", 64'(M_AXI_RREADY), 64'd0);
      M_AXI_ARREADY = 1'b1;
      @(posedge CLK);
      #1 M_AXI_ARREADY = 1'b0;
      @(negedge CLK);
      check("arvalid_drop", 64'(M_AXI_ARVALID), 64'd0);
      check("rready_on", 64'(M_AXI_RREADY), 64'd1);
   endtask

   task automatic do_beats(input vec_t v, input int n);
      wr_t e;
      for (int b = 0; b < n; b++) begin
         repeat (v.gap) @(negedge CLK);
         M_AXI_RVALID = 1'b1;
         M_AXI_RDATA  = {v.dpat, 32'(b)};
         M_AXI_RRESP  = (b == v.bad_beat) ? 2'b10 : 2'b00;
         M_AXI_RLAST  = (b == v.last_beat);
         check("rready_beat", 64'(M_AXI_RREADY), 64'd1);
         @(posedge CLK);
         #1;
         e.a = v.base + 32'(8 * b);
         e.d = {v.dpat, 32'(b)};
         exp_q.push_back(e);
         M_AXI_RVALID = 1'b0;
         M_AXI_RLAST  = 1'b0;
         M_AXI_RRESP  = 2'b00;
         @(negedge CLK);
      end
   endtask

   task automatic finish_check(input vec_t v, input int wr0, input int tag0);
      int t = 0;
      while (!done && t < 20) begin
         @(negedge CLK);
         t++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("err_at_done", 64'(err), 64'(v.exp_err));
      check("ready_low_at_done", 64'(req_ready), 64'd0);
      @(negedge CLK);
      check("done_pulse", 64'(done), 64'd0);
      check("ready_after_done", 64'(req_ready), 64'd1);
      check("write_count", 64'(n_wr - wr0), 64'(BEATS));
      check("tag_count", 64'(n_tag - tag0), 64'(v.exp_tags));
      check("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic run(input vec_t v);
      int wr0;
      int tag0;
      wr0  = n_wr;
      tag0 = n_tag;
      do_req(v);
      do_ar(v);
      do_beats(v, BEATS);
      finish_check(v, wr0, tag0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //          addr           base           way   ard gap bad last dpat          err tags
      vecs[0] = '{32'h8000_0123, 32'h8000_0000, 1'b1, 0, 0, 99, 63, 32'h0000_0000, 1'b0, 1};
      vecs[1] = '{32'h0000_1FFF, 32'h0000_1E00, 1'b1, 5, 0, 99, 63, 32'hA5A5_0001, 1'b0, 1};
      vecs[2] = '{32'h1234_5678, 32'h1234_5600, 1'b1, 1, 2, 99, 63, 32'h5A5A_0002, 1'b0, 1};
      vecs[3] = '{32'hFFFF_FE08, 32'hFFFF_FE00, 1'b1, 0, 0, 17, 63, 32'hC0DE_0003, 1'b1, 0};
      vecs[4] = '{32'h4000_0200, 32'h4000_0200, 1'b1, 2, 0, 99, 40, 32'hBEEF_0004, 1'b1, 0};
      vecs[5] = '{32'h0000_01FF, 32'h0000_0000, 1'b1, 0, 1, 99, 63, 32'h1357_0005, 1'b0, 1};

      RSTn          = 1'b0;
      req_valid     = 1'b0;
      req_addr      = 32'd0;
      req_way       = '0;
      M_AXI_ARREADY = 1'b0;
      M_AXI_RDATA   = 64'd0;
      M_AXI_RRESP   = 2'b00;
      M_AXI_RLAST   = 1'b0;
      M_AXI_RVALID  = 1'b0;
      repeat (3) @(negedge CLK);
      check_idle_outs("reset");
      RSTn = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 6; i++) begin
         run(vecs[i]);
      end

      // Reset arrives while beat 30 is on the bus; the burst is abandoned.
      do_req(vecs[1]);
      do_ar(vecs[1]);
      do_beats(vecs[1], 30);
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 64'h1E;
      #2 RSTn = 1'b0;
      @(negedge CLK);
      check_idle_outs("mid_reset");
      M_AXI_RVALID = 1'b0;
      exp_q.delete();
      RSTn = 1'b1;
      @(negedge CLK);
      check_idle_outs("post_reset");
      run(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
